// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep sequencer for one sawtooth generator channel: steps the
// increment word from a start to a stop bound, holding each point for dwell+1 cycles.
module awg_sweep_ctrl #(
  parameter int DWELL_W = 16,
  parameter int FREQ_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [FREQ_W-1:0]  freq_start,
  input  logic [FREQ_W-1:0]  freq_stop,
  input  logic [FREQ_W-1:0]  freq_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [2:0]         amp_in,
  output logic               gen_en,
  output logic [FREQ_W-1:0]  gen_freq,
  output logic [2:0]         gen_amp,
  output logic [FREQ_W-1:0]  pt_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_reg;
  logic                cont_reg;
  logic                up_reg;
  logic [FREQ_W-1:0]   fstart_reg;
  logic [FREQ_W-1:0]   fstop_reg;
  logic [FREQ_W-1:0]   fstep_reg;
  logic [DWELL_W-1:0]  dwell_reg;
  logic [DWELL_W-1:0]  dwell_cnt_reg;
  logic                gen_en_reg;
  logic [FREQ_W-1:0]   gen_freq_reg;
  logic [2:0]          gen_amp_reg;
  logic [FREQ_W-1:0]   pt_idx_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [FREQ_W:0]     sum_next;
  logic [FREQ_W:0]     diff_next;
  logic [FREQ_W-1:0]   freq_next;
  logic                in_bound_next;
  logic [2:0]          amp_clamped_next;

  // One extra bit catches carry-out on the way up and borrow on the way down.
  assign sum_next  = {1'b0, gen_freq_reg} + {1'b0, fstep_reg};
  assign diff_next = {1'b0, gen_freq_reg} - {1'b0, fstep_reg};

  always_comb begin
    freq_next     = sum_next[FREQ_W-1:0];
    in_bound_next = 1'b0;
    if (up_reg) begin
      in_bound_next = !sum_next[FREQ_W] && (sum_next[FREQ_W-1:0] <= fstop_reg);
    end else begin
      freq_next     = diff_next[FREQ_W-1:0];
      in_bound_next = !diff_next[FREQ_W] && (diff_next[FREQ_W-1:0] >= fstop_reg);
    end
    if (fstep_reg == '0) in_bound_next = 1'b0;
  end

  // The generator divides by amp, so zero would be illegal downstream.
  assign amp_clamped_next = (amp_in == 3'd0) ? 3'd1 : amp_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cont_reg      <= 1'b0;
      up_reg        <= 1'b1;
      fstart_reg    <= '0;
      fstop_reg     <= '0;
      fstep_reg     <= '0;
      dwell_reg     <= '0;
      dwell_cnt_reg <= '0;
      gen_en_reg    <= 1'b0;
      gen_freq_reg  <= '0;
      gen_amp_reg   <= 3'd1;
      pt_idx_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start && !stop) begin
            cont_reg      <= cont;
            up_reg        <= (freq_start <= freq_stop);
            fstart_reg    <= freq_start;
            fstop_reg     <= freq_stop;
            fstep_reg     <= freq_step;
            dwell_reg     <= dwell;
            gen_amp_reg   <= amp_clamped_next;
            gen_freq_reg  <= freq_start;
            pt_idx_reg    <= '0;
            dwell_cnt_reg <= '0;
            gen_en_reg    <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
            gen_en_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else if (dwell_cnt_reg == dwell_reg) begin
            dwell_cnt_reg <= '0;
            if (in_bound_next) begin
              gen_freq_reg <= freq_next;
              pt_idx_reg   <= pt_idx_reg + 1'b1;
            end else if (cont_reg) begin
              gen_freq_reg <= fstart_reg;
              pt_idx_reg   <= '0;
            end else begin
              gen_en_reg <= 1'b0;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= FIN;
            end
          end else begin
            dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
          end
        end

        FIN: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gen_en   = gen_en_reg;
  assign gen_freq = gen_freq_reg;
  assign gen_amp  = gen_amp_reg;
  assign pt_idx   = pt_idx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Directed bench for awg_sweep_ctrl: table of single sweeps plus hand-written
// sequences for continuous wrap, stop/start priority, amp clamp and reset.
module tb_awg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, cont;
  logic [11:0] freq_start, freq_stop, freq_step;
  logic [15:0] dwell;
  logic [2:0]  amp_in;
  logic        gen_en, busy, done;
  logic [11:0] gen_freq, pt_idx;
  logic [2:0]  gen_amp;

  int n_chk  = 0;
  int n_fail = 0;

  awg_sweep_ctrl #(.DWELL_W(16), .FREQ_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .freq_start(freq_start), .freq_stop(freq_stop), .freq_step(freq_step),
    .dwell(dwell), .amp_in(amp_in), .gen_en(gen_en), .gen_freq(gen_freq),
    .gen_amp(gen_amp), .pt_idx(pt_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]       fs;
    logic [11:0]       fe;
    logic [11:0]       st;
    logic [15:0]       dw;
    logic [2:0]        amp;
    logic [2:0]        exp_amp;
    logic [2:0]        n;
    logic [3:0][11:0]  pts;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(int fs, int fe, int st, int dw, int amp, int eamp,
                              int n, int p0, int p1, int p2, int p3);
    vec_t v;
    v.fs = 12'(fs); v.fe = 12'(fe); v.st = 12'(st); v.dw = 16'(dw);
    v.amp = 3'(amp); v.exp_amp = 3'(eamp); v.n = 3'(n);
    v.pts[0] = 12'(p0); v.pts[1] = 12'(p1); v.pts[2] = 12'(p2); v.pts[3] = 12'(p3);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, ".gen_en"},   gen_en,   0);
    chk({tag, ".gen_freq"}, gen_freq, 0);
    chk({tag, ".gen_amp"},  gen_amp,  1);
    chk({tag, ".pt_idx"},   pt_idx,   0);
    chk({tag, ".busy"},     busy,     0);
    chk({tag, ".done"},     done,     0);
  endtask

  task automatic drive_cfg(int fs, int fe, int st, int dw, int amp, logic c);
    freq_start = 12'(fs); freq_stop = 12'(fe); freq_step = 12'(st);
    dwell = 16'(dw); amp_in = 3'(amp); cont = c;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_single(vec_t v, int id);
    int first_fail;
    first_fail = n_fail;
    drive_cfg(v.fs, v.fe, v.st, v.dw, v.amp, 1'b0);
    pulse_start();
    for (int p = 0; p < int'(v.n); p++) begin
      for (int k = 0; k <= int'(v.dw); k++) begin
        chk("sweep.gen_freq", gen_freq, v.pts[p]);
        chk("sweep.pt_idx",   pt_idx,   p);
        chk("sweep.gen_en",   gen_en,   1);
        chk("sweep.busy",     busy,     1);
        chk("sweep.done",     done,     0);
        chk("sweep.gen_amp",  gen_amp,  v.exp_amp);
        step();
      end
    end
    chk("fin.done",     done,     1);
    chk("fin.gen_en",   gen_en,   0);
    chk("fin.busy",     busy,     0);
    chk("fin.gen_freq", gen_freq, v.pts[v.n - 1]);
    chk("fin.pt_idx",   pt_idx,   v.n - 1);
    step();
    chk("idle.done", done, 0);
    chk("idle.busy", busy, 0);
    $display("vec %0d: fs=%0d fe=%0d step=%0d dwell=%0d points=%0d errors=%0d",
             id, v.fs, v.fe, v.st, v.dw, v.n, n_fail - first_fail);
  endtask

  initial begin
    vecs[0] = mk(100, 400, 100, 3, 2, 2, 4, 100, 200, 300, 400);
    vecs[1] = mk(10, 35, 10, 0, 3, 3, 3, 10, 20, 30, 0);
    vecs[2] = mk(50, 20, 15, 0, 0, 1, 3, 50, 35, 20, 0);
    vecs[3] = mk(7, 100, 0, 2, 7, 7, 1, 7, 0, 0, 0);
    vecs[4] = mk(30, 0, 20, 1, 1, 1, 2, 30, 10, 0, 0);
    vecs[5] = mk(4000, 4095, 100, 0, 4, 4, 1, 4000, 0, 0, 0);

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 1'b0);
    step(); step();
    rst = 1'b0;
    chk_reset_vals("reset");
    $display("reset: initial values checked");

    for (int i = 0; i < 6; i++) run_single(vecs[i], i);

    // Continuous wrap near full scale; amp change and start pulse mid-sweep.
    drive_cfg(4000, 4095, 50, 1, 0, 1'b1);
    pulse_start();
    for (int c = 0; c <= 12; c++) begin
      chk("cont.gen_freq", gen_freq, ((c / 2) % 2 == 1) ? 4050 : 4000);
      chk("cont.pt_idx",   pt_idx,   (c / 2) % 2);
      chk("cont.gen_en",   gen_en,   1);
      chk("cont.done",     done,     0);
      chk("cont.gen_amp",  gen_amp,  1);
      if (c == 4) begin
        start = 1'b1; amp_in = 3'd5; freq_start = 12'd7;
      end else begin
        start = 1'b0;
      end
      if (c == 12) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    chk("stop.gen_en",   gen_en,   0);
    chk("stop.busy",     busy,     0);
    chk("stop.done",     done,     0);
    chk("stop.gen_freq", gen_freq, 4000);
    step();
    chk("stop.no_done", done, 0);
    $display("cont wrap 4000/4050 with mid-sweep start, amp change and stop");

    // Zero step in continuous mode holds freq_start forever.
    drive_cfg(9, 50, 0, 0, 2, 1'b1);
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      chk("step0.gen_freq", gen_freq, 9);
      chk("step0.pt_idx",   pt_idx,   0);
      chk("step0.gen_en",   gen_en,   1);
      chk("step0.done",     done,     0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("step0.stop_busy", busy, 0);
    $display("step0 continuous: freq held at 9");

    // start and stop together in IDLE: nothing starts.
    drive_cfg(100, 400, 100, 3, 2, 1'b0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("startstop.busy",   busy,   0);
      chk("startstop.gen_en", gen_en, 0);
      step();
    end
    $display("start+stop in IDLE: stayed idle");

    // Reset during RUN.
    drive_cfg(100, 400, 100, 3, 2, 1'b0);
    pulse_start();
    step(); step(); step(); step(); step();
    chk("rstrun.pre_freq", gen_freq, 200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("rst_run");
    $display("reset during RUN checked");

    // Reset during FIN.
    drive_cfg(10, 35, 10, 0, 3, 1'b0);
    pulse_start();
    step(); step(); step();
    chk("rstfin.pre_done", done, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("rst_fin");
    $display("reset during FIN checked");

    run_single(vecs[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
